// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the load/store path.
//   lsu_state_t : LSU control states (IDLE, WAIT, RESP).
//   F3_*        : funct3 access-size codes, shared with the control decoder's
//                 S-type and L-type encodings.
package rv32i_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   funct3_i   : access size code (B, H, W, BU, HU)
//   off_i      : byte offset within the word, a[1:0]
//   wdata_i    : store data from rs2
//   rdata_i    : read word from the bus
//   be_o       : byte enables for a store of this size and offset
//   wdata_o    : store data with the low byte or half replicated to every lane
//   rdata_o    : selected byte or half of rdata_i, sign- or zero-extended
//   misalign_o : misaligned offset or size code that is not a load/store size
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Halfword lane comes from off_i[1] only; an odd offset is flagged anyway.
  assign rbyte = rdata_i[{off_i, 3'b000} +: 8];
  assign rhalf = rdata_i[{off_i[1], 4'b0000} +: 16];

  // NOTE: every output gets a default before the case so no path through
  // this block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o    = 4'b0001 << off_i;
        // Replicating the byte puts it in whichever lane be_o selects.
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = (funct3_i == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      F3_H, F3_HU: begin
        be_o       = 4'b0011 << off_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = (funct3_i == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
        misalign_o = off_i[0];
      end
      F3_W: begin
        be_o       = 4'b1111;
        rdata_o    = rdata_i;
        misalign_o = (off_i != 2'b00);
      end
      default: misalign_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// Load/store unit between the RV32I datapath and a valid/ack data bus.
// Ports:
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   req_*              : core request (valid, we, funct3, byte addr, store data)
//   stall              : core must hold PC and request
//   rsp_valid          : one-cycle completion pulse with rsp_rdata and error flags
//   err_align          : misaligned or illegal-size access
//   err_timeout        : slave never acknowledged within TIMEOUT_CYCLES
//   bus_req/we/addr/be/wdata : registered bus request, word-aligned address
//   bus_ack, bus_rdata : slave completion and read word
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_W      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err_align,
  output logic              err_timeout,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  // Counter value in the last WAIT cycle before the access is aborted.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t            state_q, state_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]            f3_q, f3_d;
  logic [1:0]            off_q, off_d;
  logic                  bus_req_q, bus_req_d;
  logic                  bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]     bus_addr_q, bus_addr_d;
  logic [3:0]            bus_be_q, bus_be_d;
  logic [31:0]           bus_wdata_q, bus_wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  err_align_q, err_align_d;
  logic                  err_timeout_q, err_timeout_d;

  // The lane logic looks at the live request in IDLE and at the latched
  // size/offset while waiting for the read word.
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_misalign;
  logic        req_bad;

  assign al_f3  = (state_q == IDLE) ? req_funct3    : f3_q;
  assign al_off = (state_q == IDLE) ? req_addr[1:0] : off_q;

  lsu_align u_align (
    .funct3_i   (al_f3),
    .off_i      (al_off),
    .wdata_i    (req_wdata),
    .rdata_i    (bus_rdata),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata),
    .misalign_o (al_misalign)
  );

  // Unsigned sizes only exist for loads.
  assign req_bad = al_misalign || (req_we && req_funct3[2]);

  assign stall = ((state_q == IDLE) && req_valid) || (state_q == WAIT);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    f3_d          = f3_q;
    off_d         = off_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_be_d      = bus_be_q;
    bus_wdata_d   = bus_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    err_align_d   = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            err_align_d = 1'b1;
          end else begin
            state_d     = WAIT;
            cnt_d       = '0;
            f3_d        = req_funct3;
            off_d       = req_addr[1:0];
            bus_req_d   = 1'b1;
            bus_we_d    = req_we;
            bus_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            bus_be_d    = req_we ? al_be : 4'b1111;
            bus_wdata_d = req_we ? al_wdata : 32'd0;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus_ack) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_we_q ? 32'd0 : al_rdata;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST)) begin
          state_d       = RESP;
          bus_req_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          err_timeout_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      f3_q          <= '0;
      off_q         <= '0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_be_q      <= '0;
      bus_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      err_align_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_be_q      <= bus_be_d;
      bus_wdata_q   <= bus_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      err_align_q   <= err_align_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_be      = bus_be_q;
  assign bus_wdata   = bus_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign err_align   = err_align_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_rv32i_lsu.sv
// Self-checking bench for rv32i_lsu: table of directed accesses against a
// memory-model slave, plus sequences for reset mid-WAIT, back-to-back
// accesses and a disabled timeout.
module tb_rv32i_lsu;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        stall, rsp_valid, err_align, err_timeout;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  // Second instance with the timeout disabled; its bus never acknowledges.
  logic        z_req_valid = 1'b0;
  logic        z_stall, z_rsp_valid, z_err_align, z_err_timeout;
  logic [31:0] z_rsp_rdata;
  logic        z_bus_req, z_bus_we;
  logic [31:0] z_bus_addr, z_bus_wdata;
  logic [3:0]  z_bus_be;
  logic        z_bus_ack = 1'b0;
  logic [31:0] z_bus_rdata = 32'd0;

  int n_checks = 0;
  int n_err    = 0;

  rv32i_lsu #(.ADDR_W(32), .TIMEOUT_W(8), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .err_align(err_align), .err_timeout(err_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  rv32i_lsu #(.ADDR_W(32), .TIMEOUT_W(8), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(z_stall), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
    .err_align(z_err_align), .err_timeout(z_err_timeout),
    .bus_req(z_bus_req), .bus_we(z_bus_we), .bus_addr(z_bus_addr), .bus_be(z_bus_be),
    .bus_wdata(z_bus_wdata), .bus_ack(z_bus_ack), .bus_rdata(z_bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory-model slave: acks after ack_delay cycles of bus_req (never if <0).
  logic [31:0] mem [0:16383];
  int ack_delay  = 0;
  int req_cycles = 0;

  always @(negedge clk) begin
    logic [31:0] w;
    if (!bus_req) begin
      bus_ack    = 1'b0;
      req_cycles = 0;
    end else begin
      if (ack_delay >= 0 && req_cycles == ack_delay) begin
        bus_ack   = 1'b1;
        w         = mem[bus_addr[15:2]];
        bus_rdata = w;
        if (bus_we) begin
          for (int b = 0; b < 4; b++)
            if (bus_be[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
          mem[bus_addr[15:2]] = w;
        end
      end else begin
        bus_ack = 1'b0;
      end
      req_cycles++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;    // word preloaded in memory for loads
    int          dly;      // slave wait cycles before ack, -1 = never
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        ealign;
    logic        etmo;
    int          lat;      // request cycle to rsp_valid cycle, inclusive
    int          stalls;
    int          reqs;     // cycles with bus_req high
  } vec_t;

  vec_t vt[$];

  task automatic run_vec(input string tag, input vec_t v);
    int cyc = 0, stalls = 0, reqs = 0;
    bit got = 0, bus_seen = 0;
    @(negedge clk);
    ack_delay = v.dly;
    if (!v.we) mem[v.addr[15:2]] = v.rdata;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    #1;
    while (!got && cyc < 40) begin
      if (stall) stalls++;
      if (bus_req) begin
        reqs++;
        if (!bus_seen) begin
          bus_seen = 1;
          check({tag, " bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
          check({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, v.be});
          check({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, v.we});
          if (v.we) check({tag, " bus_wdata"}, bus_wdata, v.exp_wdata);
        end
      end
      if (rsp_valid) begin
        got = 1;
        check({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, " err_align"}, {31'd0, err_align}, {31'd0, v.ealign});
        check({tag, " err_timeout"}, {31'd0, err_timeout}, {31'd0, v.etmo});
      end else begin
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    req_valid = 1'b0;
    check({tag, " rsp_valid seen"}, {31'd0, got}, 32'd1);
    check({tag, " latency"}, cyc + 1, v.lat);
    check({tag, " stall cycles"}, stalls, v.stalls);
    check({tag, " bus_req cycles"}, reqs, v.reqs);
  endtask

  // Waits (bounded) for rsp_valid, sampling #1 after each falling edge.
  task automatic wait_rsp(input string tag);
    int cyc = 0;
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({tag, " rsp_valid seen"}, {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    vec_t v;
    bit z_resp;

    // we  f3     addr      wdata         rdata         dly be      exp_wdata     exp_rdata    al tmo lat st rq
    vt.push_back('{1'b1, F3_B,  32'h1003, 32'h000000A5, 32'h0,        2, 4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0, 5, 4, 3});
    vt.push_back('{1'b0, F3_B,  32'h2002, 32'h0,        32'h12F45678, 0, 4'b1111, 32'h0,        32'hFFFFFFF4, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_BU, 32'h2002, 32'h0,        32'h12F45678, 0, 4'b1111, 32'h0,        32'h000000F4, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_H,  32'h2002, 32'h0,        32'h12F45678, 0, 4'b1111, 32'h0,        32'h000012F4, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_HU, 32'h2000, 32'h0,        32'h12F48765, 0, 4'b1111, 32'h0,        32'h00008765, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_H,  32'h2000, 32'h0,        32'h12F48765, 0, 4'b1111, 32'h0,        32'hFFFF8765, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_B,  32'h2001, 32'h0,        32'h12F48765, 0, 4'b1111, 32'h0,        32'hFFFFFF87, 1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_W,  32'h2004, 32'h0,        32'hDEADBEEF, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 4, 3, 2});
    vt.push_back('{1'b1, F3_H,  32'h1002, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b1, F3_W,  32'h1004, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 4, 3, 2});
    vt.push_back('{1'b1, F3_B,  32'h1001, 32'h00000011, 32'h0,        0, 4'b0010, 32'h11111111, 32'h0,        1'b0, 1'b0, 3, 2, 1});
    vt.push_back('{1'b0, F3_W,  32'h3002, 32'h0,        32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0});
    vt.push_back('{1'b0, F3_H,  32'h3001, 32'h0,        32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0});
    vt.push_back('{1'b0, 3'b011, 32'h3000, 32'h0,       32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0});
    vt.push_back('{1'b1, 3'b100, 32'h3000, 32'h77,      32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0});
    vt.push_back('{1'b0, 3'b110, 32'h3000, 32'h0,       32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0, 2, 1, 0});
    vt.push_back('{1'b0, F3_HU, 32'h4002, 32'h0,        32'hFFFF0000, -1, 4'b1111, 32'h0,       32'h0,        1'b0, 1'b1, 6, 5, 4});

    // Reset state.
    #1;
    check("reset bus_req", {31'd0, bus_req}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset bus_addr", bus_addr, 32'd0);
    check("reset bus_be", {28'd0, bus_be}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec($sformatf("vec%0d", i), vt[i]);

    // Reset asserted in the middle of a store's WAIT.
    @(negedge clk);
    ack_delay  = -1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h6000;
    req_wdata  = 32'h0000_0055;
    @(negedge clk);
    #1;
    check("rstwait bus_req before", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rstwait bus_req", {31'd0, bus_req}, 32'd0);
    check("rstwait stall", {31'd0, stall}, 32'd0);
    check("rstwait bus_be", {28'd0, bus_be}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    v = '{1'b0, F3_W, 32'h2008, 32'h0, 32'h0BADF00D, 0, 4'b1111, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, 3, 2, 1};
    run_vec("after-reset LW", v);

    // Back-to-back SW then LW to the same word, one IDLE cycle between.
    @(negedge clk);
    ack_delay  = 0;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h5000;
    req_wdata  = 32'h89ABCDEF;
    #1;
    wait_rsp("b2b SW");
    req_we = 1'b0;
    #1;
    check("b2b stall in RESP", {31'd0, stall}, 32'd0);
    @(negedge clk);
    #1;
    check("b2b gap bus_req", {31'd0, bus_req}, 32'd0);
    check("b2b gap stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    #1;
    check("b2b LW bus_req", {31'd0, bus_req}, 32'd1);
    wait_rsp("b2b LW");
    check("b2b LW rdata", rsp_rdata, 32'h89ABCDEF);
    req_valid = 1'b0;

    // Timeout disabled: the unit must sit in WAIT past a counter wrap.
    @(negedge clk);
    req_we      = 1'b0;
    req_funct3  = F3_HU;
    req_addr    = 32'h4002;
    z_req_valid = 1'b1;
    z_resp      = 0;
    repeat (300) begin
      @(negedge clk);
      #1;
      if (z_rsp_valid) z_resp = 1;
    end
    check("notmo rsp_valid never", {31'd0, z_resp}, 32'd0);
    check("notmo bus_req held", {31'd0, z_bus_req}, 32'd1);
    check("notmo stall held", {31'd0, z_stall}, 32'd1);
    z_req_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
